xz_gate_ctrl: RTL

XZ_GATE_CTRL -- requirements
Module: xz_gate_ctrl

---
 rtl/xz_gate_pkg.sv | 14 +
 rtl/xz_detect.sv | 16 +
 rtl/xz_gate_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/xz_gate_pkg.sv
// Shared types and constants for the X/Z-aware latch gate controller.
package xz_gate_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_COUNT  = 2'd1,
    ST_OPEN   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam logic [7:0]  XZ_COUNT_MAX = 8'hFF;
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/xz_detect.sv
// Flags a sample as known only when every bit is a solid 0 or 1 (X and Z both count as unknown).
module xz_detect #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_known_c
);

  always_comb begin
    o_known_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (!((i_data[i] === 1'b0) || (i_data[i] === 1'b1))) o_known_c = 1'b0;
    end
  end

endmodule

// File: rtl/xz_gate_ctrl.sv
// Opens a downstream latch after DEBOUNCE consecutive known samples; any unknown sample closes it.
module xz_gate_ctrl
  import xz_gate_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_enb,
  output logic             out_known,
  output logic [7:0]       xz_count,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_enb;
  logic               r_out_known;
  logic [7:0]         r_xz_count;
  logic               w_known;
  logic               w_xfer;

  xz_detect #(
    .WIDTH (WIDTH)
  ) u_xz_detect (
    .i_data    (in_data),
    .o_known_c (w_known)
  );

  // Only a solid 1 on in_valid counts; X/Z valid is treated as idle.
  assign w_xfer   = (in_valid === 1'b1) && (r_state != ST_FLUSH);
  assign in_ready = (r_state != ST_FLUSH);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_CLOSED: begin
        if (w_xfer && w_known) begin
          if (DEBOUNCE == 1) begin
            w_next_state = ST_OPEN;
            w_next_cnt   = '0;
          end else begin
            w_next_state = ST_COUNT;
            w_next_cnt   = CNT_W'(1);
          end
        end
      end
      ST_COUNT: begin
        if (w_xfer) begin
          if (!w_known) begin
            w_next_state = ST_CLOSED;
            w_next_cnt   = '0;
          end else if (r_cnt + CNT_W'(1) == DEB_CNT) begin
            w_next_state = ST_OPEN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt   = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_OPEN: begin
        if (w_xfer && !w_known) w_next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_next_state = ST_CLOSED;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = ST_CLOSED;
        w_next_cnt   = '0;
      end
    endcase
  end

  // out_enb tracks the next state so it flips on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_CLOSED;
      r_cnt       <= '0;
      r_out_enb   <= 1'b1;
      r_out_data  <= '0;
      r_out_known <= 1'b0;
      r_xz_count  <= 8'd0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_out_enb <= (w_next_state != ST_OPEN);
      if (w_xfer) begin
        r_out_known <= w_known;
        if (w_known) begin
          r_out_data <= in_data;
        end else if (r_xz_count != XZ_COUNT_MAX) begin
          r_xz_count <= r_xz_count + 8'd1;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_enb   = r_out_enb;
  assign out_known = r_out_known;
  assign xz_count  = r_xz_count;
  assign state     = r_state;

endmodule
